// File: rtl/control_bypass_scoreboard_pkg.sv
// Shared constants for the EX-stage bypass/hazard scoreboard.
package control_bypass_scoreboard_pkg;

  localparam int unsigned DefRegAw   = 5;
  localparam int unsigned DefNumRegs = 32;

  typedef enum logic [1:0] {
    BypRf    = 2'b00,
    BypMemwb = 2'b01,
    BypExmem = 2'b10,
    BypFill  = 2'b11
  } byp_sel_e;

endpackage

// File: rtl/control_bypass_scoreboard_bypass_operand_sel.sv
// Per-operand forwarding select and stall contribution for one EX source operand.
module control_bypass_scoreboard_bypass_operand_sel
  import control_bypass_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW = DefRegAw
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              used,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_regwrite,
  input  logic              exmem_memread,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_regwrite,
  input  logic              pend,
  input  logic              fill_match,
  output logic [1:0]        sel,
  output logic              stall_term
);

  logic live;
  logic ex_hit;
  logic wb_hit;
  logic load_use;

  always_comb begin
    live     = used && (rs != '0);
    ex_hit   = exmem_regwrite && (exmem_rd == rs) && (exmem_rd != '0);
    wb_hit   = memwb_regwrite && (memwb_rd == rs) && (memwb_rd != '0);
    load_use = exmem_memread && exmem_regwrite && (exmem_rd == rs);

    if (ex_hit) begin
      sel = BypExmem;
    end else if (wb_hit) begin
      sel = BypMemwb;
    end else if (fill_match && pend) begin
      sel = BypFill;
    end else begin
      sel = BypRf;
    end

    // A pending register is fine to read only when its refill lands this cycle.
    stall_term = live && (load_use || (pend && !fill_match));
  end

endmodule

// File: rtl/control_bypass_scoreboard.sv
// EX-stage bypass/hazard control with a scoreboard of outstanding miss loads.
module control_bypass_scoreboard
  import control_bypass_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned REG_AW   = DefRegAw,
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned MAX_PEND = 4,
  parameter int unsigned PERF_W   = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_SRC*REG_AW-1:0]       idex_rs,
  input  logic [NUM_SRC-1:0]              idex_rs_used,
  input  logic [REG_AW-1:0]               exmem_rd,
  input  logic                            exmem_regwrite,
  input  logic                            exmem_memread,
  input  logic [REG_AW-1:0]               memwb_rd,
  input  logic                            memwb_regwrite,
  input  logic                            ld_miss_valid,
  input  logic [REG_AW-1:0]               ld_miss_rd,
  input  logic                            fill_valid,
  input  logic [REG_AW-1:0]               fill_rd,
  output logic [2*NUM_SRC-1:0]            bypass_sel,
  output logic                            stall,
  output logic                            miss_ready,
  output logic [$clog2(MAX_PEND+1)-1:0]   pend_cnt,
  output logic                            fill_err,
  output logic [PERF_W-1:0]               stall_cycles
);

  localparam int unsigned CntW = $clog2(MAX_PEND + 1);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CntW-1:0]     pend_cnt_q, pend_cnt_d;
  logic                fill_err_q, fill_err_d;
  logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic [NUM_SRC-1:0]  stall_terms;
  logic                fill_hit;
  logic                miss_acc;
  logic                waw_block;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_opnd
    logic [REG_AW-1:0] rs;
    assign rs = idex_rs[i*REG_AW +: REG_AW];

    control_bypass_scoreboard_bypass_operand_sel #(
      .REG_AW(REG_AW)
    ) u_sel (
      .rs             (rs),
      .used           (idex_rs_used[i]),
      .exmem_rd       (exmem_rd),
      .exmem_regwrite (exmem_regwrite),
      .exmem_memread  (exmem_memread),
      .memwb_rd       (memwb_rd),
      .memwb_regwrite (memwb_regwrite),
      .pend           (pending_q[rs]),
      .fill_match     (fill_valid && (fill_rd == rs)),
      .sel            (bypass_sel[2*i +: 2]),
      .stall_term     (stall_terms[i])
    );
  end

  always_comb begin
    stall     = |stall_terms;
    fill_hit  = fill_valid && (fill_rd != '0) && pending_q[fill_rd];
    waw_block = (ld_miss_rd != '0) && pending_q[ld_miss_rd]
                && !(fill_valid && (fill_rd == ld_miss_rd));
    // A same-cycle accepted fill frees a slot, so a full scoreboard can still take the miss.
    miss_ready = ((pend_cnt_q < CntW'(MAX_PEND)) || fill_hit) && !waw_block;
    miss_acc   = ld_miss_valid && miss_ready && (ld_miss_rd != '0);

    pending_d = pending_q;
    if (fill_hit) pending_d[fill_rd] = 1'b0;
    if (miss_acc) pending_d[ld_miss_rd] = 1'b1;

    pend_cnt_d = pend_cnt_q;
    case ({miss_acc, fill_hit})
      2'b10:   pend_cnt_d = pend_cnt_q + CntW'(1);
      2'b01:   pend_cnt_d = pend_cnt_q - CntW'(1);
      default: pend_cnt_d = pend_cnt_q;
    endcase

    fill_err_d = fill_err_q || (fill_valid && !fill_hit);

    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + PERF_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q      <= '0;
      pend_cnt_q     <= '0;
      fill_err_q     <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      pending_q      <= pending_d;
      pend_cnt_q     <= pend_cnt_d;
      fill_err_q     <= fill_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pend_cnt     = pend_cnt_q;
  assign fill_err     = fill_err_q;
  assign stall_cycles = stall_cycles_q;

endmodule
